// File: rtl/addsub_result_stage.sv
// addsub_result_stage: registered flag/result stage behind the 64-bit adder/subtractor.
// Two-entry skid buffer on a valid/ready handshake. Optional signed saturation: ADDSUB_SAT_EN.
`default_nettype none

// +----------------------------------------------------------------------+
// | Module   : addsub_result_stage                                       |
// | Purpose  : Z/N/C/V derivation, optional saturation, skid-buffered    |
// |            output handshake, saturating overflow event counter       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module addsub_result_stage #(
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_s,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_s,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    // State bits are {main_full, skid_full}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    logic [W-1:0]       main_s_q;
    logic [3:0]         main_f_q;
    logic [W-1:0]       skid_s_q;
    logic [3:0]         skid_f_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               w_b_eff;
    logic               w_v;
    logic [W-1:0]       w_res;
    logic [3:0]         w_flags;
    logic               w_in_xfer;
    logic               w_drain;

    assign w_b_eff = in_b_msb ^ in_sub;
    assign w_v     = (in_a_msb == w_b_eff) & (in_s[W-1] != in_a_msb);

`ifdef ADDSUB_SAT_EN
    // Clamp toward the sign of operand a: positive overflow -> max, negative -> min.
    assign w_res = w_v ? {in_a_msb, {(W-1){~in_a_msb}}} : in_s;
`else
    assign w_res = in_s;
`endif

    assign w_flags   = {w_v, in_cout, w_res[W-1], (w_res == '0)};

    // Both handshake signals decode straight from state register bits.
    assign in_ready  = ~state_q[0];
    assign out_valid = state_q[1];
    assign out_s     = main_s_q;
    assign out_flags = main_f_q;
    assign ovf_cnt   = cnt_q;

    assign w_in_xfer = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            main_s_q <= '0;
            main_f_q <= 4'b0000;
            skid_s_q <= '0;
            skid_f_q <= 4'b0000;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        main_s_q <= w_res;
                        main_f_q <= w_flags;
                        state_q  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_drain) begin
                        main_s_q <= w_res;
                        main_f_q <= w_flags;
                    end else if (w_in_xfer) begin
                        skid_s_q <= w_res;
                        skid_f_q <= w_flags;
                        state_q  <= ST_TWO;
                    end else if (w_drain) begin
                        state_q  <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        main_s_q <= skid_s_q;
                        main_f_q <= skid_f_q;
                        state_q  <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clr) begin
            cnt_d = '0;
        end else if (w_in_xfer && w_v && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire
